// File: rtl/hdmi_video_timing.sv
// Raster timing master: counters -> request stage (pixelRequest/x/y) -> output stage (rgbOut/syncs), one cycle apart.
// Defining HDMI_TIMING_TEST_PATTERN_EN adds a testMode input that swaps active video for 8 colour bars.
module hdmi_video_timing #(
    parameter int   hLength      = 12,
    parameter int   vLength      = 12,
    parameter int   hActive      = 1280,
    parameter int   hFront       = 110,
    parameter int   hSyncWidth   = 40,
    parameter int   hBack        = 220,
    parameter int   vActive      = 720,
    parameter int   vFront       = 5,
    parameter int   vSyncWidth   = 5,
    parameter int   vBack        = 20,
    parameter logic syncPolarity = 1'b1
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               enable,
    input  logic [23:0]        pixelData,
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    input  logic               testMode,
`endif
    output logic               pixelRequest,
    output logic [hLength-1:0] xLocation,
    output logic [vLength-1:0] yLocation,
    output logic [23:0]        rgbOut,
    output logic               hSync,
    output logic               vSync,
    output logic               dataEnable,
    output logic               frameStart
);

    // state | meaning
    // IDLE  | counters parked at 0, outputs quiescent, waiting for enable
    // RUN   | raster counting; leaves only on the last pixel of a frame

    localparam int hTotal = hActive + hFront + hSyncWidth + hBack;
    localparam int vTotal = vActive + vFront + vSyncWidth + vBack;

    localparam logic [hLength-1:0] hActiveW    = hLength'(hActive);
    localparam logic [hLength-1:0] hSyncStartW = hLength'(hActive + hFront);
    localparam logic [hLength-1:0] hSyncEndW   = hLength'(hActive + hFront + hSyncWidth);
    localparam logic [hLength-1:0] hLastW      = hLength'(hTotal - 1);
    localparam logic [vLength-1:0] vActiveW    = vLength'(vActive);
    localparam logic [vLength-1:0] vSyncStartW = vLength'(vActive + vFront);
    localparam logic [vLength-1:0] vSyncEndW   = vLength'(vActive + vFront + vSyncWidth);
    localparam logic [vLength-1:0] vLastW      = vLength'(vTotal - 1);

    if (hTotal > (2 ** hLength)) begin : gHFit
        $error("hdmi_video_timing: horizontal total does not fit in hLength");
    end
    if (vTotal > (2 ** vLength)) begin : gVFit
        $error("hdmi_video_timing: vertical total does not fit in vLength");
    end

    typedef enum logic {IDLE, RUN} stateT;

    stateT              state;
    stateT              nextState;
    logic [hLength-1:0] hCount;
    logic [vLength-1:0] vCount;
    logic               frameEnd;
    logic               inActive;
    logic               hSyncNow;
    logic               vSyncNow;
    logic               hSyncD;
    logic               vSyncD;
    logic [23:0]        pixelSel;

    assign frameEnd = (hCount == hLastW) && (vCount == vLastW);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (enable) nextState = RUN;
            RUN:     if (frameEnd && !enable) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            hCount <= '0;
            vCount <= '0;
        end else if (state == RUN) begin
            if (hCount == hLastW) begin
                hCount <= '0;
                vCount <= (vCount == vLastW) ? '0 : vCount + vLength'(1);
            end else begin
                hCount <= hCount + hLength'(1);
            end
        end else begin
            hCount <= '0;
            vCount <= '0;
        end
    end

    assign inActive = (state == RUN) && (hCount < hActiveW) && (vCount < vActiveW);
    assign hSyncNow = ((state == RUN) && (hCount >= hSyncStartW) && (hCount < hSyncEndW))
                      ? syncPolarity : ~syncPolarity;
    assign vSyncNow = ((state == RUN) && (vCount >= vSyncStartW) && (vCount < vSyncEndW))
                      ? syncPolarity : ~syncPolarity;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pixelRequest <= 1'b0;
            xLocation    <= '0;
            yLocation    <= '0;
            frameStart   <= 1'b0;
            hSyncD       <= ~syncPolarity;
            vSyncD       <= ~syncPolarity;
        end else begin
            pixelRequest <= inActive;
            xLocation    <= inActive ? hCount : '0;
            yLocation    <= inActive ? vCount : '0;
            frameStart   <= (state == RUN) && (hCount == '0) && (vCount == '0);
            hSyncD       <= hSyncNow;
            vSyncD       <= vSyncNow;
        end
    end

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    localparam logic [hLength-1:0] barWidth = hLength'(hActive / 8);

    logic [2:0]  barIdx;
    logic [23:0] barColor;

    // xLocation is the registered request column, so the bar lines up with dataEnable.
    assign barIdx = 3'(xLocation / barWidth);

    always_comb begin
        barColor = 24'h000000;
        case (barIdx)
            3'd0: barColor = 24'hffffff;
            3'd1: barColor = 24'hffff00;
            3'd2: barColor = 24'h00ffff;
            3'd3: barColor = 24'h00ff00;
            3'd4: barColor = 24'hff00ff;
            3'd5: barColor = 24'hff0000;
            3'd6: barColor = 24'h0000ff;
            3'd7: barColor = 24'h000000;
        endcase
    end

    assign pixelSel = testMode ? barColor : pixelData;
`else
    assign pixelSel = pixelData;
`endif

    // pixelData is only looked at when the request was issued, so blanking never leaks source junk.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rgbOut     <= '0;
            dataEnable <= 1'b0;
            hSync      <= ~syncPolarity;
            vSync      <= ~syncPolarity;
        end else begin
            rgbOut     <= pixelRequest ? pixelSel : '0;
            dataEnable <= pixelRequest;
            hSync      <= hSyncD;
            vSync      <= vSyncD;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing on a shrunk raster; a frame-position model predicts every output each cycle.
module tb_hdmi_video_timing;
    localparam int HL = 8, VL = 8;
    localparam int HA = 16, HF = 3, HSW = 4, HB = 5;
    localparam int VA = 6, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam logic POL = 1'b1;
    localparam logic [23:0] BARS [0:7] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                          24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};
    localparam logic [44:0] RST_VEC = {1'b0, 8'h00, 8'h00, 24'h000000, ~POL, ~POL, 1'b0, 1'b0};

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          enable = 1'b0;
    logic [23:0]   pixelData = '0;
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    logic          testMode = 1'b0;
`endif
    logic          pixelRequest;
    logic [HL-1:0] xLocation;
    logic [VL-1:0] yLocation;
    logic [23:0]   rgbOut;
    logic          hSync, vSync, dataEnable, frameStart;

    int vectors = 0;
    int miscompares = 0;
    int dataMode = 0;

    hdmi_video_timing #(
        .hLength(HL), .vLength(VL),
        .hActive(HA), .hFront(HF), .hSyncWidth(HSW), .hBack(HB),
        .vActive(VA), .vFront(VF), .vSyncWidth(VSW), .vBack(VB),
        .syncPolarity(POL)
    ) dut (
        .clock(clock), .resetN(resetN), .enable(enable), .pixelData(pixelData),
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        .testMode(testMode),
`endif
        .pixelRequest(pixelRequest), .xLocation(xLocation), .yLocation(yLocation),
        .rgbOut(rgbOut), .hSync(hSync), .vSync(vSync),
        .dataEnable(dataEnable), .frameStart(frameStart)
    );

    always #5 clock = ~clock;

    // Reference: one integer frame position; request outputs lag it one cycle, video outputs two.
    logic          mRun = 1'b0;
    int            mPos = 0;
    int            cx, cy;
    logic          act;
    logic          h1, v1;
    logic          expReq, expFs, expDe, expH, expV;
    logic [HL-1:0] expX, expOutX;
    logic [VL-1:0] expY, expOutY;
    logic [23:0]   expRgb;
    logic [44:0]   obsVec, expVec;

    always_comb begin
        cx  = mPos % HT;
        cy  = mPos / HT;
        act = mRun && (cx < HA) && (cy < VA);
    end

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mRun <= 1'b0; mPos <= 0; h1 <= ~POL; v1 <= ~POL;
            expReq <= 1'b0; expFs <= 1'b0; expDe <= 1'b0; expH <= ~POL; expV <= ~POL;
            expX <= '0; expY <= '0; expOutX <= '0; expOutY <= '0; expRgb <= '0;
        end else begin
            if (!expReq) expRgb <= '0;
`ifdef HDMI_TIMING_TEST_PATTERN_EN
            else if (testMode) expRgb <= BARS[int'(expX) / (HA / 8)];
`endif
            else expRgb <= pixelData;
            expDe   <= expReq;
            expH    <= h1;
            expV    <= v1;
            expOutX <= expX;
            expOutY <= expY;
            expReq  <= act;
            expX    <= act ? cx[HL-1:0] : '0;
            expY    <= act ? cy[VL-1:0] : '0;
            expFs   <= mRun && (mPos == 0);
            h1 <= (mRun && cx >= HA + HF && cx < HA + HF + HSW) ? POL : ~POL;
            v1 <= (mRun && cy >= VA + VF && cy < VA + VF + VSW) ? POL : ~POL;
            if (!mRun) begin
                if (enable) begin mRun <= 1'b1; mPos <= 0; end
            end else if (mPos == HT * VT - 1) begin
                mPos <= 0;
                if (!enable) mRun <= 1'b0;
            end else begin
                mPos <= mPos + 1;
            end
        end
    end

    assign obsVec = {pixelRequest, xLocation, yLocation, rgbOut, hSync, vSync, dataEnable, frameStart};
    assign expVec = {expReq, expX, expY, expRgb, expH, expV, expDe, expFs};

    // Pixel source: answers a request with {y, x, A5}, otherwise drives junk.
    task automatic drive_data();
        case (dataMode)
            1:       pixelData = 24'hFFFFFF;
            2:       pixelData = 24'($urandom);
            default: pixelData = pixelRequest ? {yLocation, xLocation, 8'hA5} : 24'($urandom);
        endcase
    endtask

    task automatic test_reset();
        resetN = 1'b0; enable = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++; if (rgbOut !== 24'h0) begin miscompares++; $display("FAIL reset_rgb got %h want 000000", rgbOut); end
        vectors++; if (hSync !== ~POL) begin miscompares++; $display("FAIL reset_hsync got %b want %b", hSync, ~POL); end
        vectors++; if (vSync !== ~POL) begin miscompares++; $display("FAIL reset_vsync got %b want %b", vSync, ~POL); end
        vectors++; if (pixelRequest !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", pixelRequest); end
        vectors++; if (dataEnable !== 1'b0) begin miscompares++; $display("FAIL reset_de got %b want 0", dataEnable); end
        vectors++; if (frameStart !== 1'b0) begin miscompares++; $display("FAIL reset_fs got %b want 0", frameStart); end
        vectors++; if (xLocation !== '0) begin miscompares++; $display("FAIL reset_x got %0d want 0", xLocation); end
        vectors++; if (yLocation !== '0) begin miscompares++; $display("FAIL reset_y got %0d want 0", yLocation); end
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== RST_VEC) begin miscompares++; $display("FAIL idle_hold got %h want %h", obsVec, RST_VEC); end
            drive_data();
        end
    endtask

    task automatic test_frame();
        int req = 0, hp = 0, hw = 0, badW = 0, vw = 0, fs = 0;
        logic prevH = ~POL;
        dataMode = 0;
        enable = 1'b1; drive_data();
        @(negedge clock);
        enable = 1'b0; drive_data();
        for (int i = 0; i < HT * VT + 10; i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL frame_vec t=%0t got %h want %h", $time, obsVec, expVec); end
            if (expDe && int'(expOutX) == 5 && int'(expOutY) == 3) begin
                vectors++; if (rgbOut !== 24'h0305A5) begin miscompares++; $display("FAIL frame_pix53 got %h want 0305a5", rgbOut); end
            end
            if (!expDe) begin
                vectors++; if (rgbOut !== 24'h0) begin miscompares++; $display("FAIL frame_blank got %h want 000000", rgbOut); end
            end
            if (pixelRequest === 1'b1) req++;
            if (frameStart === 1'b1) fs++;
            if (vSync === POL) vw++;
            if (hSync === POL) hw++;
            else if (prevH === POL) begin hp++; if (hw != HSW) badW++; hw = 0; end
            prevH = hSync;
            drive_data();
        end
        vectors++; if (req != HA * VA) begin miscompares++; $display("FAIL frame_requests got %0d want %0d", req, HA * VA); end
        vectors++; if (hp != VT) begin miscompares++; $display("FAIL frame_hpulses got %0d want %0d", hp, VT); end
        vectors++; if (badW != 0) begin miscompares++; $display("FAIL frame_hwidth got %0d bad pulses want 0", badW); end
        vectors++; if (vw != VSW * HT) begin miscompares++; $display("FAIL frame_vsync got %0d want %0d", vw, VSW * HT); end
        vectors++; if (fs != 1) begin miscompares++; $display("FAIL frame_starts got %0d want 1", fs); end
    endtask

    task automatic test_white();
        logic chkZero = 1'b0;
        int tail = 0;
        dataMode = 1;
        enable = 1'b1; drive_data();
        for (int i = 0; i < HT * VT + 2 * HT; i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL white_vec t=%0t got %h want %h", $time, obsVec, expVec); end
            vectors++; if (rgbOut !== (expDe ? 24'hFFFFFF : 24'h0)) begin miscompares++; $display("FAIL white_rgb got %h de_model %b", rgbOut, expDe); end
            if (chkZero) begin
                vectors++; if (rgbOut !== 24'h0 || dataEnable !== 1'b0) begin miscompares++; $display("FAIL white_after_last got %h/%b want 000000/0", rgbOut, dataEnable); end
                chkZero = 1'b0;
            end
            if (expDe && int'(expOutX) == HA - 1) begin
                vectors++; if (rgbOut !== 24'hFFFFFF) begin miscompares++; $display("FAIL white_last_pixel got %h want ffffff", rgbOut); end
                chkZero = 1'b1;
            end
            drive_data();
        end
        enable = 1'b0;
        for (int i = 0; i < 2 * HT * VT && (mRun || tail < 4); i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL white_drain got %h want %h", obsVec, expVec); end
            if (!mRun) tail++;
            drive_data();
        end
        vectors++; if (mRun) begin miscompares++; $display("FAIL white_timeout got running want idle"); end
    endtask

    task automatic test_enable_drop();
        int line = $urandom_range(1, VA - 1);
        int maxY = 0, vw = 0, tail = 0;
        logic hit = 1'b0;
        dataMode = 0;
        enable = 1'b1; drive_data();
        for (int i = 0; i < 2 * HT * VT; i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL drop_run got %h want %h", obsVec, expVec); end
            drive_data();
            if (expReq && int'(expY) == line) begin hit = 1'b1; break; end
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL drop_timeout got no line %0d want reached", line); end
        enable = 1'b0;
        for (int i = 0; i < 2 * HT * VT && (mRun || tail < 6); i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL drop_vec got %h want %h", obsVec, expVec); end
            if (pixelRequest === 1'b1 && int'(yLocation) > maxY) maxY = int'(yLocation);
            if (vSync === POL) vw++;
            if (!mRun) begin
                tail++;
                if (tail > 2) begin
                    vectors++; if (pixelRequest !== 1'b0 || hSync !== ~POL) begin miscompares++; $display("FAIL drop_idle got req %b hsync %b want 0/%b", pixelRequest, hSync, ~POL); end
                end
            end
            drive_data();
        end
        vectors++; if (maxY != VA - 1) begin miscompares++; $display("FAIL drop_lastline got %0d want %0d", maxY, VA - 1); end
        vectors++; if (vw != VSW * HT) begin miscompares++; $display("FAIL drop_vsync got %0d want %0d", vw, VSW * HT); end
        enable = 1'b1; drive_data();
        @(negedge clock);
        vectors++; if (frameStart !== 1'b0 || pixelRequest !== 1'b0) begin miscompares++; $display("FAIL reenable_early got fs %b req %b want 0/0", frameStart, pixelRequest); end
        drive_data();
        @(negedge clock);
        vectors++; if (frameStart !== 1'b1 || pixelRequest !== 1'b1 || xLocation !== '0 || yLocation !== '0) begin
            miscompares++; $display("FAIL reenable_start got fs %b req %b x %0d y %0d want 1/1/0/0", frameStart, pixelRequest, xLocation, yLocation);
        end
        drive_data();
        for (int i = 0; i < HT; i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL reenable_vec got %h want %h", obsVec, expVec); end
            drive_data();
        end
    endtask

    task automatic test_reset_midframe();
        int rx = $urandom_range(0, HA - 1);
        int ry = $urandom_range(1, VA - 1);
        int tail = 0;
        logic hit = 1'b0;
        dataMode = 0;
        enable = 1'b1;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL rstmid_run got %h want %h", obsVec, expVec); end
            if (expReq && int'(expX) == rx && int'(expY) == ry) begin hit = 1'b1; break; end
            drive_data();
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL rstmid_timeout got no (%0d,%0d) want reached", rx, ry); end
        #2 resetN = 1'b0;
        #1;
        vectors++; if (obsVec !== RST_VEC) begin miscompares++; $display("FAIL rstmid_async got %h want %h", obsVec, RST_VEC); end
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1; drive_data();
        @(negedge clock);
        vectors++; if (frameStart !== 1'b0 || pixelRequest !== 1'b0) begin miscompares++; $display("FAIL rstmid_early got fs %b req %b want 0/0", frameStart, pixelRequest); end
        drive_data();
        @(negedge clock);
        vectors++; if (frameStart !== 1'b1 || xLocation !== '0 || yLocation !== '0) begin
            miscompares++; $display("FAIL rstmid_restart got fs %b x %0d y %0d want 1/0/0", frameStart, xLocation, yLocation);
        end
        drive_data();
        for (int i = 0; i < 2 * HT; i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL rstmid_vec got %h want %h", obsVec, expVec); end
            drive_data();
        end
        enable = 1'b0;
        for (int i = 0; i < 2 * HT * VT && (mRun || tail < 4); i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL rstmid_drain got %h want %h", obsVec, expVec); end
            if (!mRun) tail++;
            drive_data();
        end
        vectors++; if (mRun) begin miscompares++; $display("FAIL rstmid_idle_timeout got running want idle"); end
    endtask

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    task automatic test_pattern();
        int tail = 0;
        testMode = 1'b1;
        dataMode = 2;
        enable = 1'b1; drive_data();
        for (int i = 0; i < HT * VT + HT; i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL bars_vec got %h want %h", obsVec, expVec); end
            if (expDe && int'(expOutX) == 0) begin
                vectors++; if (rgbOut !== 24'hffffff) begin miscompares++; $display("FAIL bars_x0 got %h want ffffff", rgbOut); end
            end
            if (expDe && int'(expOutX) == HA / 8) begin
                vectors++; if (rgbOut !== 24'hffff00) begin miscompares++; $display("FAIL bars_x1 got %h want ffff00", rgbOut); end
            end
            if (expDe && int'(expOutX) == HA - 1) begin
                vectors++; if (rgbOut !== 24'h000000) begin miscompares++; $display("FAIL bars_xlast got %h want 000000", rgbOut); end
            end
            drive_data();
        end
        enable = 1'b0;
        for (int i = 0; i < 2 * HT * VT && (mRun || tail < 4); i++) begin
            @(negedge clock);
            vectors++; if (obsVec !== expVec) begin miscompares++; $display("FAIL bars_drain got %h want %h", obsVec, expVec); end
            if (!mRun) tail++;
            drive_data();
        end
        testMode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_white();
        test_enable_drop();
        test_reset_midframe();
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
